// File: rtl/axi_rr_interconnect_if.sv
// Bundled AXI channel signals for one side of the round-robin interconnect.
// N=NUM_MASTERS on the master side, N=1 on the slave side.
interface axi_rr_interconnect_if #(
    parameter int N      = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 2
);
    localparam int STRB_W = DATA_W / 8;
    localparam int AWP    = ADDR_W + 13;
    localparam int WP     = DATA_W + STRB_W + 1;
    localparam int ARP    = ID_W + ADDR_W + 13;
    localparam int RP     = ID_W + DATA_W + 3;

    logic [N*AWP-1:0] awp;
    logic [N-1:0]     awvalid;
    logic [N-1:0]     awready;
    logic [N*WP-1:0]  wp;
    logic [N-1:0]     wvalid;
    logic [N-1:0]     wready;
    logic [N-1:0]     bvalid;
    logic [N-1:0]     bready;
    logic [2*N-1:0]   bresp;
    logic [N*ARP-1:0] arp;
    logic [N-1:0]     arvalid;
    logic [N-1:0]     arready;
    logic [N*RP-1:0]  rp;
    logic [N-1:0]     rvalid;
    logic [N-1:0]     rready;

    modport master (
        output awp, awvalid, wp, wvalid, bready, arp, arvalid, rready,
        input  awready, wready, bvalid, bresp, arready, rp, rvalid
    );

    modport slave (
        input  awp, awvalid, wp, wvalid, bready, arp, arvalid, rready,
        output awready, wready, bvalid, bresp, arready, rp, rvalid
    );
endinterface

// File: rtl/axi_rr_interconnect.sv
// N-master to 1-slave AXI interconnect with round-robin registered grant
// and a local decode-error responder for addresses outside the slave window.
module axi_rr_interconnect #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 2,
    parameter int DEC_HI      = 31,
    parameter int DEC_LO      = 26
) (
    input  logic                  aclk,
    input  logic                  areset,
    axi_rr_interconnect_if.slave  s,
    axi_rr_interconnect_if.master m
);
    localparam int N      = NUM_MASTERS;
    localparam int STRB_W = DATA_W / 8;
    localparam int AWP    = ADDR_W + 13;
    localparam int WP     = DATA_W + STRB_W + 1;
    localparam int ARP    = ID_W + ADDR_W + 13;
    localparam int RP     = ID_W + DATA_W + 3;
    localparam int GW     = $clog2(N);
    localparam int DW     = DEC_HI - DEC_LO + 1;

    typedef enum logic [2:0] {
        IDLE, WR, RD, DW_A, DW_D, DW_B, DR_A, DR_D
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   g_q, g_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [7:0]      rlen_q, rlen_d;
    logic [7:0]      cnt_q, cnt_d;

    logic [N-1:0]    req;
    logic [GW-1:0]   win;
    logic            found;
    logic            win_wr;
    logic            hit_w;
    logic            hit_r;

    logic [AWP-1:0]  g_awp;
    logic [WP-1:0]   g_wp;
    logic [ARP-1:0]  g_arp;

    logic [N-1:0]    awready_o, wready_o, bvalid_o;
    logic [N-1:0]    arready_o, rvalid_o;
    logic [2*N-1:0]  bresp_o;
    logic [N*RP-1:0] rp_o;
    logic [AWP-1:0]  m_awp_o;
    logic [WP-1:0]   m_wp_o;
    logic [ARP-1:0]  m_arp_o;
    logic            m_awvalid_o, m_wvalid_o, m_bready_o;
    logic            m_arvalid_o, m_rready_o;

    assign req = s.awvalid | s.arvalid;

    // first requester at or after the round-robin pointer, wrapping at N
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr_q) + k) % N]) begin
                found = 1'b1;
                win   = GW'((int'(ptr_q) + k) % N);
            end
        end
    end

    assign win_wr = s.awvalid[win];
    assign hit_w  = ~|s.awp[int'(win)*AWP + 13 + DEC_LO +: DW];
    assign hit_r  = ~|s.arp[int'(win)*ARP + 13 + DEC_LO +: DW];

    assign g_awp = s.awp[int'(g_q)*AWP +: AWP];
    assign g_wp  = s.wp[int'(g_q)*WP +: WP];
    assign g_arp = s.arp[int'(g_q)*ARP +: ARP];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            rid_q   <= '0;
            rlen_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            rid_q   <= rid_d;
            rlen_q  <= rlen_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        ptr_d       = ptr_q;
        rid_d       = rid_q;
        rlen_d      = rlen_q;
        cnt_d       = cnt_q;
        awready_o   = '0;
        wready_o    = '0;
        bvalid_o    = '0;
        arready_o   = '0;
        rvalid_o    = '0;
        bresp_o     = '0;
        rp_o        = '0;
        m_awp_o     = '0;
        m_wp_o      = '0;
        m_arp_o     = '0;
        m_awvalid_o = 1'b0;
        m_wvalid_o  = 1'b0;
        m_bready_o  = 1'b0;
        m_arvalid_o = 1'b0;
        m_rready_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    g_d   = win;
                    ptr_d = GW'((int'(win) + 1) % N);
                    if (win_wr)
                        state_d = hit_w ? WR : DW_A;
                    else
                        state_d = hit_r ? RD : DR_A;
                end
            end
            WR: begin
                m_awp_o        = g_awp;
                m_awvalid_o    = s.awvalid[g_q];
                awready_o[g_q] = m.awready;
                m_wp_o         = g_wp;
                m_wvalid_o     = s.wvalid[g_q];
                wready_o[g_q]  = m.wready;
                m_bready_o     = s.bready[g_q];
                bvalid_o[g_q]  = m.bvalid;
                bresp_o[int'(g_q)*2 +: 2] = m.bresp;
                if (m.bvalid && s.bready[g_q])
                    state_d = IDLE;
            end
            RD: begin
                m_arp_o        = g_arp;
                m_arvalid_o    = s.arvalid[g_q];
                arready_o[g_q] = m.arready;
                m_rready_o     = s.rready[g_q];
                rvalid_o[g_q]  = m.rvalid;
                rp_o[int'(g_q)*RP +: RP] = m.rp;
                // rlast alone is not a completion; it must ride a valid beat
                if (m.rvalid && m.rp[0] && s.rready[g_q])
                    state_d = IDLE;
            end
            DW_A: begin
                awready_o[g_q] = 1'b1;
                if (s.awvalid[g_q])
                    state_d = DW_D;
            end
            DW_D: begin
                wready_o[g_q] = 1'b1;
                if (s.wvalid[g_q] && g_wp[0])
                    state_d = DW_B;
            end
            DW_B: begin
                bvalid_o[g_q] = 1'b1;
                bresp_o[int'(g_q)*2 +: 2] = 2'b11;
                if (s.bready[g_q])
                    state_d = IDLE;
            end
            DR_A: begin
                arready_o[g_q] = 1'b1;
                if (s.arvalid[g_q]) begin
                    rid_d   = g_arp[ARP-1 -: ID_W];
                    rlen_d  = g_arp[12:5];
                    cnt_d   = '0;
                    state_d = DR_D;
                end
            end
            DR_D: begin
                rvalid_o[g_q] = 1'b1;
                rp_o[int'(g_q)*RP +: RP] =
                    {rid_q, {DATA_W{1'b0}}, 2'b11, cnt_q == rlen_q};
                if (s.rready[g_q]) begin
                    if (cnt_q == rlen_q)
                        state_d = IDLE;
                    else
                        cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s.awready = awready_o;
    assign s.wready  = wready_o;
    assign s.bvalid  = bvalid_o;
    assign s.bresp   = bresp_o;
    assign s.arready = arready_o;
    assign s.rvalid  = rvalid_o;
    assign s.rp      = rp_o;

    assign m.awp     = m_awp_o;
    assign m.awvalid = m_awvalid_o;
    assign m.wp      = m_wp_o;
    assign m.wvalid  = m_wvalid_o;
    assign m.bready  = m_bready_o;
    assign m.arp     = m_arp_o;
    assign m.arvalid = m_arvalid_o;
    assign m.rready  = m_rready_o;
endmodule

// File: doc/axi_rr_interconnect.md
Name: axi_rr_interconnect

Overview:
- Parametrised N-master to 1-slave AXI interconnect; successor to the fixed two-master, priority-based interconnect.
- Adds round-robin fairness, a registered grant, and an `rvalid`-qualified read completion.
- Adds an internal decode-error responder: requests outside the slave window complete locally and are never forwarded.
- Sits between the CPU/DMA masters and the single memory-side slave port.

Parameters:
NUM_MASTERS, 2, master count, legal range 2..8
ADDR_W, 32, address width
DATA_W, 32, data width; STRB_W = DATA_W/8
ID_W, 2, read ID width
DEC_HI, 31, upper bit of the decode field
DEC_LO, 26, lower bit of the decode field; hit when addr[DEC_HI:DEC_LO] == 0
Derived payload widths:
- AWP = ADDR_W+13, packed {addr, len[7:0], size[2:0], burst[1:0]}
- WP = DATA_W+STRB_W+1, packed {data, strb, last}
- ARP = ID_W+ADDR_W+13, packed {id, addr, len, size, burst}
- RP = ID_W+DATA_W+3, packed {id, data, resp[1:0], last}

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
s_awp, s_wp, s_arp  in  N*AWP, N*WP, N*ARP  master-side payloads; slice i belongs to master i
s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready  in  N each  master-side valid/ready; bit i is master i
s_awready, s_wready, s_bvalid, s_arready, s_rvalid  out  N each  master-side ready/valid
s_bresp  out  2*N  per-master write response
s_rp  out  N*RP  per-master read payload
m_awp, m_wp, m_arp  out  AWP, WP, ARP  slave-side payloads
m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready  out  1 each  slave-side valid/ready
m_awready, m_wready, m_bvalid, m_arready, m_rvalid  in  1 each  slave-side ready/valid
m_bresp  in  2  slave write response
m_rp  in  RP  slave read payload

Behaviour:
- Reset (asynchronous, areset=1):
  - state=IDLE, rr_ptr=0, grant g=0, beat counter=0.
  - Every output is 0.
  - Reset asserted mid-transaction abandons the transaction; no response is generated.
- States: IDLE, WR, RD, DW_A, DW_D, DW_B, DR_A, DR_D.
- IDLE arbitration:
  - req[i] = s_awvalid[i] | s_arvalid[i].
  - Scan from rr_ptr upward, wrapping at N; the first requester wins and becomes g. Grant is registered.
  - rr_ptr <= (g+1) mod N on every grant.
  - If master g asserts both awvalid and arvalid, the write is taken.
  - Hit test uses s_awp[g] (write) or s_arp[g] (read). Next state: WR on write hit, RD on read hit, DW_A on write miss, DR_A on read miss.
  - In IDLE no ready/valid output is asserted and all payloads are 0.
- Latency:
  - A request visible before edge k is forwarded (m_*valid high) in the cycle after edge k.
  - Forwarding paths are combinational from the registered g.
- WR:
  - AW, W and B channels route between master g and the slave; s_*ready[g]=m_*ready and s_bvalid[g]=m_bvalid.
  - m_arvalid=0 and m_rready=0.
  - Exit to IDLE on m_bvalid & s_bready[g].
- RD:
  - AR and R channels route the same way; AW, W and B are idle.
  - Exit to IDLE on m_rvalid & m_rp.last & s_rready[g]. rlast without rvalid does not end the transaction.
- Non-granted masters: all ready/valid outputs 0, all payloads 0, at all times.
- DW_A: s_awready[g]=1; on AW handshake go to DW_D.
- DW_D: s_wready[g]=1; beats are discarded; on a handshake with last=1 go to DW_B.
- DW_B: s_bvalid[g]=1, s_bresp=2'b11 (DECERR); held until s_bready[g], then IDLE.
- DR_A: s_arready[g]=1; on handshake latch id and len; counter=0; go to DR_D.
- DR_D:
  - s_rvalid[g]=1, data=0, resp=2'b11, id=latched id, last=(counter==len).
  - counter increments on each rready; after the last beat, go to IDLE.
  - len=255 produces 256 beats; the counter is 8-bit and does not wrap before last.
- A grantee that drops valid before its handshake is not timed out; the FSM waits.
- Requests arriving from other masters during a transaction wait; they are re-arbitrated in IDLE.
- The slave never sees a miss transaction.

Test Plan:
- Single master: M0 writes addr 0x0000_0100, len=0 -> m_awvalid high 1 cycle after request; M0 receives bresp=0 on slave B; FSM returns to IDLE.
- Fairness, N=3: M0, M1 and M2 hold continuous reads -> grant order 0,1,2,0,1; no master is granted twice before the others.
- Decode miss: M1 reads 0x0400_0000, len=3, id=2 -> 4 beats, rresp=2'b11, rid=2, rlast on beat 4 only; m_arvalid never rises.
- Write miss: M0 writes 0xFC00_0000 with 2 beats -> both W beats accepted, bresp=2'b11; m_awvalid and m_wvalid stay 0.
- Completion qualification: slave drives rlast=1 with rvalid=0 during RD -> state stays RD; the later rvalid&rlast&rready returns the FSM to IDLE.
- Reset mid-WR: assert areset -> all outputs 0 immediately, rr_ptr=0; the next request is granted from M0.
